lii_stream_adapter: RTL

Parametrised LII-to-kernel stream adapter that sits between one physical LII input/output channel pair and an HLS kernel's AXI-Stream ports. It unpacks each PW-bit LII word into PW/IW kernel input beats and packs OW-bit kernel output beats into PW-bit LII words. It adds registered buffering on both sides, destination filtering, fixed-length output framing with zero-padded partial-word flush, and kernel clock-enable generation. It is the next generation of the per-kernel stream wrappers, which only truncate or forward a single beat.

---
 rtl/lii_pkg.sv | 8 +
 rtl/lii_unpacker.sv | 85 ++++++++
 rtl/lii_stream_adapter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lii_pkg.sv
// Shared LII definitions: routing tag width and address type.
package lii_pkg;

    localparam int LII_TAG_W = 8;

    typedef logic [LII_TAG_W-1:0] lii_addr_t;

endpackage

// File: rtl/lii_unpacker.sv
// LII word unpacker: holds one PW-bit word and feeds it to the kernel as
// PW/IW beats, LSB-first. Words addressed elsewhere are accepted and counted
// in a saturating drop counter, but they are never loaded.
module lii_unpacker
    import lii_pkg::*;
#(
    parameter int        PW    = 64,
    parameter int        IW    = 8,
    parameter lii_addr_t MY_ID = 8'd1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] word_i,
    input  logic          word_valid_i,
    input  lii_addr_t     word_dst_i,
    output logic          word_ready_o,
    output logic [IW-1:0] beat_o,
    output logic          beat_valid_o,
    input  logic          beat_ready_i,
    output logic [15:0]   drop_cnt_o
);

    localparam int NB   = PW / IW;
    localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NB - 1);

    logic [PW-1:0]   hold_q, hold_d;
    logic            hold_valid_q, hold_valid_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;

    logic idx_last, accept, load, drop, beat_fire;

    // A transfer happens on a cycle where valid and ready are both high; valid
    // never depends on ready, and an offered beat or word stays put until taken.
    assign idx_last     = (idx_q == IDX_LAST);
    assign word_ready_o = !hold_valid_q || (idx_last && beat_ready_i);
    assign accept       = word_valid_i && word_ready_o;
    assign load         = accept && (word_dst_i == MY_ID);
    assign drop         = accept && (word_dst_i != MY_ID);
    assign beat_fire    = hold_valid_q && beat_ready_i;

    assign beat_o       = hold_q[idx_q*IW +: IW];
    assign beat_valid_o = hold_valid_q;
    assign drop_cnt_o   = drop_cnt_q;

    // Next-state: a new load wins over the last beat leaving in the same cycle.
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        idx_d        = idx_q;
        drop_cnt_d   = drop_cnt_q;
        if (load) begin
            hold_d       = word_i;
            hold_valid_d = 1'b1;
            idx_d        = '0;
        end else if (beat_fire) begin
            if (idx_last) begin
                hold_valid_d = 1'b0;
                idx_d        = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Register the holding word, beat index and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            idx_q        <= '0;
            drop_cnt_q   <= '0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            idx_q        <= idx_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

endmodule

// File: rtl/lii_stream_adapter.sv
// LII-to-kernel stream adapter: unpacks LII words into kernel input beats,
// packs kernel output beats into fixed-length, zero-padded LII frames, and
// freezes the kernel only while its output is blocked.
module lii_stream_adapter
    import lii_pkg::*;
#(
    parameter int        PW        = 64,
    parameter int        IW        = 8,
    parameter int        OW        = 16,
    parameter lii_addr_t MY_ID     = 8'd1,
    parameter lii_addr_t DST_ID    = 8'd2,
    parameter int        FRAME_OUT = 16
) (
    input  logic          aclk,
    input  logic          arstn,
    input  logic [PW-1:0] lii_in_p0_tdata,
    input  logic          lii_in_p0_tvalid,
    output logic          lii_in_p0_tready,
    input  lii_addr_t     lii_in_p0_src,
    input  lii_addr_t     lii_in_p0_dst,
    output logic [PW-1:0] lii_out_p0_tdata,
    output logic          lii_out_p0_tvalid,
    input  logic          lii_out_p0_tready,
    output lii_addr_t     lii_out_p0_src,
    output lii_addr_t     lii_out_p0_dst,
    output logic [IW-1:0] in_stream_tdata,
    output logic          in_stream_tvalid,
    input  logic          in_stream_tready,
    input  logic [OW-1:0] out_stream_tdata,
    input  logic          out_stream_tvalid,
    output logic          out_stream_tready,
    output logic          ce,
    output logic [15:0]   drop_cnt
);

    localparam int NL = PW / OW;
    localparam int LW = (NL > 1) ? $clog2(NL) : 1;
    localparam int FW = (FRAME_OUT > 1) ? $clog2(FRAME_OUT) : 1;
    localparam logic [LW-1:0] LANE_LAST  = LW'(NL - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_OUT - 1);

    if ((PW % IW) != 0) begin : g_bad_iw
        $error("lii_stream_adapter: IW must divide PW");
    end
    if ((PW % OW) != 0) begin : g_bad_ow
        $error("lii_stream_adapter: OW must divide PW");
    end
    if (FRAME_OUT < 1) begin : g_bad_frame
        $error("lii_stream_adapter: FRAME_OUT must be at least 1");
    end

    // The source tag of incoming words carries no meaning for this kernel.
    logic unused_src;
    assign unused_src = ^lii_in_p0_src;

    lii_unpacker #(
        .PW    (PW),
        .IW    (IW),
        .MY_ID (MY_ID)
    ) u_unpacker (
        .clk          (aclk),
        .rst_n        (arstn),
        .word_i       (lii_in_p0_tdata),
        .word_valid_i (lii_in_p0_tvalid),
        .word_dst_i   (lii_in_p0_dst),
        .word_ready_o (lii_in_p0_tready),
        .beat_o       (in_stream_tdata),
        .beat_valid_o (in_stream_tvalid),
        .beat_ready_i (in_stream_tready),
        .drop_cnt_o   (drop_cnt)
    );

    logic [PW-1:0] acc_q, acc_d, acc_fill;
    logic [PW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          beat, flush, drain, frame_end;

    // Kernel beats are only taken when the output register is empty or
    // draining, so a flush can never overwrite an unsent word.
    assign out_stream_tready = !out_valid_q || lii_out_p0_tready;
    assign beat              = out_stream_tvalid && out_stream_tready;
    assign drain             = out_valid_q && lii_out_p0_tready;
    assign frame_end         = (frame_q == FRAME_LAST);
    assign flush             = beat && ((lane_q == LANE_LAST) || frame_end);

    assign lii_out_p0_tdata  = out_data_q;
    assign lii_out_p0_tvalid = out_valid_q;
    assign lii_out_p0_src    = MY_ID;
    assign lii_out_p0_dst    = DST_ID;
    assign ce                = !(out_stream_tvalid && !out_stream_tready);

    // Packer next-state: lanes above the current one are still zero in the
    // accumulator, which gives the padding of a short frame-end word for free.
    always_comb begin
        acc_fill                   = acc_q;
        acc_fill[lane_q*OW +: OW]  = out_stream_tdata;
        acc_d                      = acc_q;
        lane_d                     = lane_q;
        frame_d                    = frame_q;
        out_data_d                 = out_data_q;
        out_valid_d                = out_valid_q;
        if (drain) begin
            out_valid_d = 1'b0;
        end
        if (beat) begin
            frame_d = frame_end ? '0 : frame_q + 1'b1;
            if (flush) begin
                out_data_d  = acc_fill;
                out_valid_d = 1'b1;
                acc_d       = '0;
                lane_d      = '0;
            end else begin
                acc_d  = acc_fill;
                lane_d = lane_q + 1'b1;
            end
        end
    end

    // Register the accumulator, output word, lane and frame counters.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            lane_q      <= '0;
            frame_q     <= '0;
        end else begin
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            lane_q      <= lane_d;
            frame_q     <= frame_d;
        end
    end

endmodule
